// File: rtl/clint.sv
// Core-local interrupt/exception sequencer.
// Detects ecall/ebreak/mret in decode and enabled external interrupts
// while idle. It holds the pipeline, writes mepc/mstatus/mcause through a
// dedicated CSR write port, then issues a one-cycle redirect.
//
// Handshake: there is no back-pressure. hold_flag_o is raised in the
// detection cycle and stays high through every sequencing state. Each CSR
// write is a single-cycle strobe on we_o. The redirect is a single-cycle
// strobe on int_assert_o, with int_addr_o valid only in that cycle.
module clint #(
    parameter int          INT_W     = 8,
    parameter logic [31:0] CAUSE_EXT = 32'h8000000B
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INT_W-1:0] int_flag_i,
    input  logic [31:0]      inst_i,
    input  logic [31:0]      inst_addr_i,
    input  logic             jump_flag_i,
    input  logic [31:0]      jump_addr_i,
    input  logic [31:0]      csr_mtvec_i,
    input  logic [31:0]      csr_mepc_i,
    input  logic [31:0]      csr_mstatus_i,
    output logic             hold_flag_o,
    output logic             we_o,
    output logic [11:0]      waddr_o,
    output logic [31:0]      data_o,
    output logic             int_assert_o,
    output logic [31:0]      int_addr_o
);

    localparam logic [31:0] INST_ECALL  = 32'h00000073;
    localparam logic [31:0] INST_EBREAK = 32'h00100073;
    localparam logic [31:0] INST_MRET   = 32'h30200073;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_W_MEPC    = 3'd1,
        S_W_MSTATUS = 3'd2,
        S_W_MCAUSE  = 3'd3,
        S_ASSERT    = 3'd4,
        S_R_MSTATUS = 3'd5,
        S_R_ASSERT  = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q,   epc_d;
    logic        detect;

    logic is_ecall, is_ebreak, is_mret, ext_req;

    assign is_ecall  = (inst_i == INST_ECALL);
    assign is_ebreak = (inst_i == INST_EBREAK);
    assign is_mret   = (inst_i == INST_MRET);
    // Interrupts are masked by mstatus.MIE; exceptions and mret never are.
    assign ext_req   = (|int_flag_i) && csr_mstatus_i[3];

    // Next-state and cause/epc capture; detection is only evaluated in IDLE.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        detect  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (is_ecall || is_ebreak) begin
                    detect  = 1'b1;
                    state_d = S_W_MEPC;
                    cause_d = is_ecall ? 32'd11 : 32'd3;
                    epc_d   = inst_addr_i;
                end else if (ext_req) begin
                    detect  = 1'b1;
                    state_d = S_W_MEPC;
                    cause_d = CAUSE_EXT;
                    // A taken jump in ex means the next instruction to run is the target.
                    epc_d   = jump_flag_i ? jump_addr_i : inst_addr_i;
                end else if (is_mret) begin
                    detect  = 1'b1;
                    state_d = S_R_MSTATUS;
                end
            end
            S_W_MEPC:    state_d = S_W_MSTATUS;
            S_W_MSTATUS: state_d = S_W_MCAUSE;
            S_W_MCAUSE:  state_d = S_ASSERT;
            S_ASSERT:    state_d = S_IDLE;
            S_R_MSTATUS: state_d = S_R_ASSERT;
            S_R_ASSERT:  state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // State and latched trap context; reset abandons any sequence in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    // Output decode from the registered state; hold also covers the detection cycle.
    always_comb begin
        hold_flag_o  = detect || (state_q != S_IDLE);
        we_o         = 1'b0;
        waddr_o      = '0;
        data_o       = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        unique case (state_q)
            S_W_MEPC: begin
                we_o    = 1'b1;
                waddr_o = CSR_MEPC;
                data_o  = epc_q;
            end
            S_W_MSTATUS: begin
                // Trap entry: MPIE <= MIE, MIE <= 0.
                we_o    = 1'b1;
                waddr_o = CSR_MSTATUS;
                data_o  = {csr_mstatus_i[31:8], csr_mstatus_i[3],
                           csr_mstatus_i[6:4], 1'b0, csr_mstatus_i[2:0]};
            end
            S_W_MCAUSE: begin
                we_o    = 1'b1;
                waddr_o = CSR_MCAUSE;
                data_o  = cause_q;
            end
            S_ASSERT: begin
                int_assert_o = 1'b1;
                int_addr_o   = csr_mtvec_i;
            end
            S_R_MSTATUS: begin
                // Trap return: MIE <= MPIE, MPIE <= 1.
                we_o    = 1'b1;
                waddr_o = CSR_MSTATUS;
                data_o  = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4],
                           csr_mstatus_i[7], csr_mstatus_i[2:0]};
            end
            S_R_ASSERT: begin
                int_assert_o = 1'b1;
                int_addr_o   = csr_mepc_i;
            end
            default: begin
                we_o = 1'b0;
            end
        endcase
    end

endmodule
